// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction ROM and
// fills a one-entry IF/ID slot handed to decode over a valid/ready handshake.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 64,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_fault,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic slot_free, hs, aligned, in_range;

  assign slot_free = !vld_q || id_ready;
  assign hs        = vld_q && id_ready;
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign in_range  = (pc_q[31:2] < 30'(ROM_WORDS));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    fault_d = fault_q;
    // Hand-offs are counted even when a redirect squashes the slot.
    cnt_d   = cnt_q + {31'd0, hs};

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      vld_d   = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (slot_free) begin
        ifpc_d = pc_q;
        vld_d  = 1'b1;
        if (aligned && in_range) begin
          inst_d  = rom_data;
          fault_d = 1'b0;
          pc_d    = pc_q + 32'd4;
        end else begin
          // Faulting fetch parks the PC on the bad address until redirected.
          inst_d  = NOP_INST;
          fault_d = 1'b1;
          state_d = HALTED;
        end
      end
    end else begin
      if (id_ready) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      inst_q  <= 32'd0;
      ifpc_q  <= 32'd0;
      fault_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_valid    = vld_q;
  assign if_inst     = inst_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = ifpc_q + 32'd4;
  assign if_fault    = fault_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: ROM word i holds 0x100+i; expectations hand-computed.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr, rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, id_ready, if_fault, halted;
  logic [31:0] if_inst, if_pc, if_pc_plus4, fetch_count;

  int total = 0;
  int bad   = 0;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .id_ready(id_ready), .if_inst(if_inst), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_fault(if_fault), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign rom_data = 32'h100 + {2'b00, rom_addr[31:2]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                      input logic flt);
    chk({tag, ".vld"}, 32'(if_valid), 32'd1);
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".inst"}, if_inst, inst);
    chk({tag, ".flt"}, 32'(if_fault), 32'(flt));
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #2;
    chk("rst.vld", 32'(if_valid), 32'd0);
    chk("rst.addr", rom_addr, 32'h0);
    chk("rst.cnt", fetch_count, 32'd0);
    chk("rst.halt", 32'(halted), 32'd0);
    chk("rst.inst", if_inst, 32'd0);
    #1 rst_n = 1'b1;

    // Sequential fetch
    step(); slot("e1", 32'h0, 32'h100, 1'b0); chk("e1.addr", rom_addr, 32'h4);
    chk("e1.pc4", if_pc_plus4, 32'h4);
    step(); slot("e2", 32'h4, 32'h101, 1'b0); chk("e2.addr", rom_addr, 32'h8);
    chk("e2.cnt", fetch_count, 32'd1);
    step(); slot("e3", 32'h8, 32'h102, 1'b0); chk("e3.cnt", fetch_count, 32'd2);

    // Backpressure for three edges
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); slot("bp", 32'h8, 32'h102, 1'b0);
      chk("bp.addr", rom_addr, 32'hC);
      chk("bp.cnt", fetch_count, 32'd2);
    end
    id_ready = 1'b1;
    step(); slot("bp.rel", 32'hC, 32'h103, 1'b0); chk("bp.rel.cnt", fetch_count, 32'd3);
    step(); slot("s10", 32'h10, 32'h104, 1'b0); chk("s10.cnt", fetch_count, 32'd4);

    // Redirect with simultaneous hand-off
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step(); chk("rd.vld", 32'(if_valid), 32'd0); chk("rd.addr", rom_addr, 32'h20);
    chk("rd.cnt", fetch_count, 32'd5);
    redirect_valid = 1'b0;
    step(); slot("rd.f", 32'h20, 32'h108, 1'b0); chk("rd.f.cnt", fetch_count, 32'd5);

    // Misaligned redirect -> fault and halt
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step(); chk("mis.addr", rom_addr, 32'h22); chk("mis.cnt", fetch_count, 32'd6);
    chk("mis.vld", 32'(if_valid), 32'd0);
    redirect_valid = 1'b0;
    step(); slot("mis.f", 32'h22, 32'h13, 1'b1); chk("mis.halt", 32'(halted), 32'd1);
    chk("mis.addr2", rom_addr, 32'h22);
    step(); chk("mis.drain", 32'(if_valid), 32'd0); chk("mis.addr3", rom_addr, 32'h22);
    chk("mis.cnt2", fetch_count, 32'd7);
    step(); chk("mis.hold", rom_addr, 32'h22); chk("mis.halt2", 32'(halted), 32'd1);
    chk("mis.vld2", 32'(if_valid), 32'd0);

    // Redirect out of HALTED
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(); chk("res.halt", 32'(halted), 32'd0); chk("res.addr", rom_addr, 32'h0);
    redirect_valid = 1'b0;
    step(); slot("res.f", 32'h0, 32'h100, 1'b0); chk("res.cnt", fetch_count, 32'd7);

    // Out-of-range boundary at word 64
    redirect_valid = 1'b1; redirect_pc = 32'hF8;
    step(); chk("oor.cnt", fetch_count, 32'd8);
    redirect_valid = 1'b0;
    step(); slot("oor.62", 32'hF8, 32'h13E, 1'b0);
    step(); slot("oor.63", 32'hFC, 32'h13F, 1'b0); chk("oor.addr", rom_addr, 32'h100);
    chk("oor.halt0", 32'(halted), 32'd0);
    step(); slot("oor.f", 32'h100, 32'h13, 1'b1); chk("oor.halt", 32'(halted), 32'd1);
    chk("oor.cnt2", fetch_count, 32'd10);

    // Async reset mid-stream
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(); redirect_valid = 1'b0;
    step(); slot("ar.pre", 32'h10, 32'h104, 1'b0); chk("ar.pre.addr", rom_addr, 32'h14);
    chk("ar.pre.cnt", fetch_count, 32'd11);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.vld", 32'(if_valid), 32'd0);
    chk("ar.addr", rom_addr, 32'h0);
    chk("ar.cnt", fetch_count, 32'd0);
    chk("ar.halt", 32'(halted), 32'd0);
    chk("ar.pc", if_pc, 32'd0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage: the reader side of the instruction ROM.
- Holds the PC and drives the ROM byte address. The ROM returns the instruction word combinationally in the same cycle.
- Registers the fetched word, its PC and a fault flag into a one-entry IF/ID slot, handed to decode with a valid/ready handshake.
- Accepts taken-branch/jump redirects from execute, detects misaligned and out-of-range fetches, and keeps a hand-off counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- ROM_WORDS, 64, ROM depth in 32-bit words; a fetch with PC[31:2] >= ROM_WORDS is out of range.
- NOP_INST, 32'h00000013, word placed in if_inst on a faulting fetch (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  32  byte address to instruction ROM; equals the PC register.
- rom_data  in  32  instruction word from ROM, valid in the same cycle as rom_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  new PC when redirect_valid=1.
- if_valid  out  1  IF/ID slot holds an instruction.
- id_ready  in  1  decode accepts the slot this cycle.
- if_inst  out  32  instruction in slot.
- if_pc  out  32  PC of slot instruction.
- if_pc_plus4  out  32  if_pc+4, combinational from if_pc.
- if_fault  out  1  slot instruction is a faulting fetch (misaligned or out of range).
- halted  out  1  fetch is stopped in HALTED state.
- fetch_count  out  32  number of slot hand-offs (if_valid && id_ready).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC; if_valid=0; if_inst=0; if_pc=0; if_fault=0.
  - state=RUN; halted=0; fetch_count=0.
  - All outputs take these values immediately, without waiting for clk.
- rom_addr=pc at all times, combinational from the register; no ROM read latency.
- slot_free = !if_valid || id_ready.
- States are RUN and HALTED; halted=1 only in HALTED.
- Per rising edge, priority order:
  1. redirect_valid=1 (any state):
     - pc<=redirect_pc; if_valid<=0 (slot squashed even if id_ready=1); state<=RUN.
     - No fetch this cycle.
     - fetch_count still increments if if_valid&&id_ready; the hand-off occurred, and decode is flushed by execute.
  2. RUN, slot_free, pc[1:0]==0 and pc[31:2]<ROM_WORDS (normal fetch):
     - if_inst<=rom_data; if_pc<=pc; if_fault<=0; if_valid<=1; pc<=pc+4.
     - pc+4 wraps modulo 2^32.
  3. RUN, slot_free, pc misaligned or out of range (faulting fetch):
     - if_inst<=NOP_INST; if_pc<=pc; if_fault<=1; if_valid<=1.
     - pc unchanged; state<=HALTED.
  4. RUN, !slot_free:
     - Hold all of pc, the slot and the state.
  5. HALTED, no redirect:
     - No fetch; pc held.
     - The slot drains normally: if_valid<=0 when id_ready=1.
- Throughput: one instruction per cycle while id_ready=1 continuously.
- First valid slot appears on the first edge after reset release.
- fetch_count increments on every edge with if_valid&&id_ready, independent of other events; it wraps at 2^32.
- if_inst, if_pc and if_fault are stable while if_valid=1 and id_ready=0.
- Redirect to a misaligned target is accepted: pc takes the value, and the next fetch faults per rule 3.

Test Plan:
- Reset release with RESET_PC=0, ROM word i = 0x100+i, id_ready=1:
  - Edge 1 gives if_valid=1, if_pc=0x0, if_inst=0x100.
  - Edge 2 gives if_pc=0x4, if_inst=0x101.
  - rom_addr steps 0x0, 0x4, 0x8.
  - fetch_count=2 after edge 3.
- Backpressure: id_ready=0 for 3 cycles with slot holding pc 0x8 → if_pc=0x8, if_inst=0x102 and rom_addr=0xC held; fetch_count unchanged. id_ready=1 → next edge if_pc=0xC.
- Redirect with simultaneous handshake: if_valid=1, if_pc=0x10, id_ready=1, redirect_pc=0x20 → next edge if_valid=0, pc=0x20, fetch_count+1. The following edge gives if_pc=0x20, if_inst=0x108.
- Misaligned redirect: redirect_pc=0x22 → pc=0x22. Next edge gives if_valid=1, if_fault=1, if_inst=0x00000013, if_pc=0x22, halted=1. Afterwards pc and rom_addr stay 0x22. A later redirect to 0x0 gives halted=0 and resumes from 0x0 with if_fault=0.
- Out-of-range: run sequentially to pc=0xFC (word 63), then pc=0x100 → word 63 delivered normally. The next slot has if_fault=1, if_pc=0x100, and halted=1.
- Asynchronous reset mid-stream: assert rst_n=0 between edges while if_valid=1, pc=0x14 → if_valid=0, rom_addr=0x0 and fetch_count=0 immediately, without a clock edge.
